// File: rtl/cac_tx_sched_if.sv
// Requester-side word handshake for the CAC transmit scheduler.
// The requester drives data/valid and the scheduler answers with ready.
interface cac_tx_sched_if #(
    parameter int unsigned DLEN = 12
) ();
    logic [DLEN-1:0] in_data;
    logic            in_valid;
    logic            in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/cac_tx_sched.sv
// CAC transmit scheduler: range-checks requester words, queues them in a small FIFO
// and launches them to the DPS-16 encoder with a fixed idle gap after each launch.
module cac_tx_sched #(
    parameter int unsigned DLEN   = 12,
    parameter int unsigned MAXVAL = 3194,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned GAP    = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    cac_tx_sched_if.slave            in_if,
    input  logic                     pause,
    output logic [DLEN-1:0]          enc_data,
    output logic                     enc_strobe,
    output logic                     range_err,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              sent_cnt,
    output logic [7:0]               drop_cnt
);
    localparam int unsigned PW       = $clog2(DEPTH);
    localparam logic [PW:0] FULL_LVL = (PW + 1)'(DEPTH);
    localparam logic [2:0]  GAP_LAST = 3'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic in_range(input logic [DLEN-1:0] d);
        return 32'(d) < MAXVAL;
    endfunction

    logic [DLEN-1:0] mem [DEPTH];
    logic [PW:0]     wr_ptr;
    logic [PW:0]     rd_ptr;
    logic [PW:0]     wr_ptr_p1;
    state_t          state;
    logic [2:0]      gap_cnt;
    logic            accept;
    logic            push;
    logic            bad;
    logic            avail;
    logic            launch_slot;
    logic            launch;

    // Accept stage: handshake and range check on the incoming word.
    assign level          = wr_ptr - rd_ptr;
    assign in_if.in_ready = (level < FULL_LVL);
    assign accept         = in_if.in_valid && in_if.in_ready;
    assign push           = accept && in_range(in_if.in_data);
    assign bad            = accept && !in_range(in_if.in_data);

    // The read side sees the write pointer one cycle late, so a freshly written
    // word becomes launchable on the second edge after its accept edge.
    assign avail = (wr_ptr_p1 != rd_ptr);

    always_comb begin
        launch_slot = 1'b0;
        case (state)
            ST_IDLE: launch_slot = 1'b1;
            ST_SEND: launch_slot = (GAP == 0);
            ST_GAP:  launch_slot = (gap_cnt == GAP_LAST);
            default: launch_slot = 1'b0;
        endcase
    end

    assign launch = launch_slot && avail && !pause;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr[PW-1:0]] <= in_if.in_data;
        end
    end

    // Queue stage: pointers carry one extra bit so full and empty stay distinct.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            wr_ptr_p1 <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (launch) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            wr_ptr_p1 <= wr_ptr;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            range_err <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            range_err <= bad;
            if (bad) begin
                drop_cnt <= sat_inc8(drop_cnt);
            end
        end
    end

    // Launch stage: enc_data only changes on a launch so the bus stays quiet when idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            gap_cnt    <= '0;
            enc_data   <= '0;
            enc_strobe <= 1'b0;
            sent_cnt   <= '0;
        end else begin
            enc_strobe <= launch;
            if (launch) begin
                state    <= ST_SEND;
                gap_cnt  <= '0;
                enc_data <= mem[rd_ptr[PW-1:0]];
                sent_cnt <= sent_cnt + 16'd1;
            end else begin
                case (state)
                    ST_SEND: state <= (GAP > 0) ? ST_GAP : ST_IDLE;
                    ST_GAP: begin
                        if (gap_cnt == GAP_LAST) begin
                            state <= ST_IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + 3'd1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cac_tx_sched.sv
// Randomized scoreboard bench for cac_tx_sched against a queue-based launch model.
// Directed sections cover reset, latency, burst spacing, range drops, full/pause and mid-burst reset.
module tb_cac_tx_sched;
    localparam int DLEN   = 12;
    localparam int MAXVAL = 3194;
    localparam int DEPTH  = 4;
    localparam int GAP    = 1;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            pause = 1'b0;
    logic [DLEN-1:0] enc_data;
    logic            enc_strobe;
    logic            range_err;
    logic [LW-1:0]   level;
    logic [15:0]     sent_cnt;
    logic [7:0]      drop_cnt;

    cac_tx_sched_if #(.DLEN(DLEN)) bus ();

    cac_tx_sched #(.DLEN(DLEN), .MAXVAL(MAXVAL), .DEPTH(DEPTH), .GAP(GAP)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_if      (bus),
        .pause      (pause),
        .enc_data   (enc_data),
        .enc_strobe (enc_strobe),
        .range_err  (range_err),
        .level      (level),
        .sent_cnt   (sent_cnt),
        .drop_cnt   (drop_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        int d;
        int e;
    } ent_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;

    // reference model state
    ent_t m_q[$];
    ent_t exp_q[$];
    int   edge_n      = 0;
    int   last_launch = -100;
    int   m_last      = 0;
    int   m_sent      = 0;
    int   m_drop      = 0;
    bit   m_rerr      = 1'b0;
    int   m_acc_in    = 0;
    int   m_acc_out   = 0;

    // observations of the DUT for directed sections
    ent_t st_log[$];
    int   rerr_cnt = 0;
    int   dut_peak = 0;
    int   rdy_low  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp, edge_n);
        end
    endtask

    // Model: a word may launch once it has sat in the queue for two edges, the link is
    // not paused, and at least 1+GAP edges have passed since the previous launch.
    initial forever begin
        @(posedge clock or posedge reset);
        if (reset) begin
            m_q.delete();
            exp_q.delete();
            last_launch = -100;
            m_last      = 0;
            m_sent      = 0;
            m_drop      = 0;
            m_rerr      = 1'b0;
            m_acc_in    = 0;
            m_acc_out   = 0;
        end else begin
            bit   acc;
            bit   lnch;
            ent_t h;
            edge_n++;
            acc  = bus.in_valid && (m_q.size() < DEPTH);
            lnch = (m_q.size() > 0) && !pause && (m_q[0].e <= edge_n - 2)
                   && (edge_n - last_launch >= 1 + GAP);
            if (lnch) begin
                h = m_q.pop_front();
                exp_q.push_back('{h.d, edge_n});
                m_last      = h.d;
                m_sent      = (m_sent + 1) % 65536;
                last_launch = edge_n;
            end
            m_rerr = acc && (int'(bus.in_data) >= MAXVAL);
            if (m_rerr) begin
                m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                m_acc_out++;
            end
            if (acc && !m_rerr) begin
                m_q.push_back('{int'(bus.in_data), edge_n});
                m_acc_in++;
            end
        end
    end

    // Monitor: compares every output once per cycle, popping the launch scoreboard on strobes.
    initial forever begin
        @(negedge clock);
        if (mon_en) begin
            bit   exp_stb;
            ent_t h;
            exp_stb = (exp_q.size() > 0) && (exp_q[0].e == edge_n);
            check("enc_strobe", 32'(enc_strobe), 32'(exp_stb));
            if (exp_stb) begin
                h = exp_q.pop_front();
                check("launch_word", 32'(enc_data), 32'(h.d));
            end
            check("enc_data_hold", 32'(enc_data), 32'(m_last));
            check("range_err", 32'(range_err), 32'(m_rerr));
            check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            check("sent_cnt", 32'(sent_cnt), 32'(m_sent));
            check("level", 32'(level), 32'(m_q.size()));
            check("in_ready", 32'(bus.in_ready), 32'(m_q.size() < DEPTH));
            if (enc_strobe) st_log.push_back('{int'(enc_data), edge_n});
            if (range_err) rerr_cnt++;
            if (int'(level) > dut_peak) dut_peak = int'(level);
            if (!bus.in_ready) rdy_low++;
        end
    end

    task automatic drive(input bit v, input int d, input bit p);
        @(negedge clock);
        bus.in_valid = v;
        bus.in_data  = d[DLEN-1:0];
        pause        = p;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_enc_data", 32'(enc_data), 32'd0);
        check("rst_enc_strobe", 32'(enc_strobe), 32'd0);
        check("rst_range_err", 32'(range_err), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_sent_cnt", 32'(sent_cnt), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        mon_en = 1'b1;
        @(negedge clock);
        reset = 1'b0;

        // single word: strobe on the second edge after the accept edge
        drive(1'b1, 356, 1'b0);
        drive(1'b0, 0, 1'b0);
        @(posedge clock);
        @(posedge clock);
        #1;
        check("single_strobe", 32'(enc_strobe), 32'd1);
        check("single_data", 32'(enc_data), 32'd356);
        @(posedge clock);
        #1;
        check("single_strobe_end", 32'(enc_strobe), 32'd0);
        check("single_sent", 32'(sent_cnt), 32'd1);
        idle(4);

        // burst of four in-range words
        st_log.delete();
        dut_peak = 0;
        rdy_low  = 0;
        drive(1'b1, 0, 1'b0);
        drive(1'b1, 1, 1'b0);
        drive(1'b1, 3193, 1'b0);
        drive(1'b1, 2000, 1'b0);
        idle(12);
        check("burst_count", 32'(st_log.size()), 32'd4);
        if (st_log.size() == 4) begin
            check("burst_w0", 32'(st_log[0].d), 32'd0);
            check("burst_w1", 32'(st_log[1].d), 32'd1);
            check("burst_w2", 32'(st_log[2].d), 32'd3193);
            check("burst_w3", 32'(st_log[3].d), 32'd2000);
            for (int i = 1; i < 4; i++)
                check("burst_spacing", 32'(st_log[i].e - st_log[i-1].e), 32'd2);
        end
        check("burst_peak_level", 32'(dut_peak), 32'd3);
        check("burst_ready_low", 32'(rdy_low), 32'd0);

        // out-of-range words are dropped
        st_log.delete();
        rerr_cnt = 0;
        drive(1'b1, 3194, 1'b0);
        drive(1'b1, 4095, 1'b0);
        idle(6);
        check("range_pulses", 32'(rerr_cnt), 32'd2);
        check("range_drop_cnt", 32'(drop_cnt), 32'd2);
        check("range_no_strobe", 32'(st_log.size()), 32'd0);
        check("range_data_held", 32'(enc_data), 32'd2000);

        // fill while paused, then release
        st_log.delete();
        for (int i = 0; i <= DEPTH; i++) drive(1'b1, 10 + i, 1'b1);
        @(negedge clock);
        check("full_level", 32'(level), 32'(DEPTH));
        check("full_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        pause        = 1'b0;
        idle(14);
        check("full_count", 32'(st_log.size()), 32'(DEPTH));
        for (int i = 0; i < DEPTH && i < st_log.size(); i++)
            check("full_order", 32'(st_log[i].d), 32'(10 + i));

        // asynchronous reset with words queued
        drive(1'b1, 100, 1'b1);
        drive(1'b1, 101, 1'b1);
        drive(1'b1, 102, 1'b1);
        drive(1'b0, 0, 1'b1);
        @(posedge clock);
        #3;
        reset = 1'b1;
        st_log.delete();
        #1;
        check("arst_level", 32'(level), 32'd0);
        check("arst_enc_data", 32'(enc_data), 32'd0);
        check("arst_enc_strobe", 32'(enc_strobe), 32'd0);
        check("arst_range_err", 32'(range_err), 32'd0);
        check("arst_sent_cnt", 32'(sent_cnt), 32'd0);
        check("arst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        pause = 1'b0;
        idle(10);
        check("arst_no_launch", 32'(st_log.size()), 32'd0);

        // random traffic with random pause
        for (int i = 0; i < 20000; i++)
            drive(($urandom % 4) != 0, int'($urandom_range(0, 4095)), ($urandom % 8) == 0);
        idle(40);
        check("rand_drained", 32'(level), 32'd0);
        check("rand_sent_total", 32'(sent_cnt), 32'(m_acc_in % 65536));
        check("rand_drop_total", 32'(drop_cnt), 32'((m_acc_out < 255) ? m_acc_out : 255));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
